// File: rtl/rv_fetch_if.sv
// Bus bundle for the instruction-fetch stage: instruction-memory port,
// decode-side IF/ID outputs, EX redirect inputs and a state debug tap.
//
// Handshake: imem_req/imem_addr are held stable until a cycle in which
// imem_gnt is high (the request is accepted in that cycle); exactly one
// imem_rvalid pulse, carrying imem_rdata, follows each accepted request
// no earlier than the cycle after the grant. At most one request is in
// flight. The only case where an unaccepted request may change its
// address is the cycle after an ex_redirect pulse.
interface rv_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic [1:0]  dbg_state;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  id_stall, ex_redirect, ex_target,
        output if_id_ir, if_id_pc, if_id_valid,
        output dbg_state
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output id_stall, ex_redirect, ex_target,
        input  if_id_ir, if_id_pc, if_id_valid,
        input  dbg_state
    );
endinterface

// File: rtl/rv_fetch.sv
// RV32 instruction fetch stage. Owns the PC, issues one word fetch at a
// time over req/gnt + rvalid, and loads the IF/ID registers. Decode
// back-pressure parks a returned word in a one-entry hold buffer; an EX
// redirect retargets the PC and kills any fetch already in flight.
module rv_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rst,
    rv_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // Word-aligned versions of the reset PC and redirect target.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_fetch_pc;    // address of the next request
    logic [31:0] r_req_pc;      // address of the request in flight
    logic        r_kill;        // in-flight response belongs to the wrong path

    logic        r_hold_valid;  // hold buffer occupied
    logic [31:0] r_hold_ir;
    logic [31:0] r_hold_pc;

    logic [31:0] r_if_id_ir;
    logic [31:0] r_if_id_pc;
    logic        r_if_id_valid;

    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_grant;       // request accepted this cycle
    logic        w_resp;        // response arrives while we wait for one
    logic        w_resp_live;   // response that is on the correct path
    logic        w_capture;     // live response parked because decode stalls
    logic        w_hold_out;    // hold buffer drains into IF/ID
    logic        w_imem_req;
    logic [1:0]  w_dbg_state;

    assign w_stall     = bus.id_stall;
    assign w_redirect  = bus.ex_redirect;
    assign w_target    = bus.ex_target & ~32'd3;
    assign w_grant     = (r_state == S_REQ) && bus.imem_gnt;
    // rvalid outside S_WAIT has no matching request and is ignored.
    assign w_resp      = (r_state == S_WAIT) && bus.imem_rvalid;
    assign w_resp_live = w_resp && !r_kill;
    assign w_capture   = w_resp_live && w_stall && !w_redirect;
    assign w_hold_out  = (r_state == S_HOLD) && r_hold_valid && !w_stall;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect never blocks leaving S_WAIT/S_HOLD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RST: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                // A grant coinciding with a redirect still leaves a fetch
                // in flight; it is killed rather than abandoned.
                if (bus.imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (r_kill || w_redirect || !w_stall) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_redirect || !w_stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_RST;
            end
        endcase
    end

    // Moore outputs of the FSM.
    always_comb begin
        w_imem_req  = 1'b0;
        w_dbg_state = r_state;
        if (r_state == S_REQ) begin
            w_imem_req = 1'b1;
        end
    end

    // Fetch PC: redirect wins over the post-grant increment, so a grant in
    // the redirect cycle leaves fetch_pc at the target, not target+4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC_ALIGNED;
        end else if (w_redirect) begin
            r_fetch_pc <= w_target;
        end else if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Remember the address of the accepted request for the IF/ID PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_pc <= 32'd0;
        end else if (w_grant) begin
            r_req_pc <= r_fetch_pc;
        end
    end

    // Kill flag: set when a redirect overtakes a fetch in flight, cleared
    // by the response it was waiting to discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kill <= 1'b0;
        end else if (w_resp) begin
            r_kill <= 1'b0;
        end else if (w_redirect && (w_grant || (r_state == S_WAIT))) begin
            r_kill <= 1'b1;
        end
    end

    // One-entry hold buffer for a word that arrives while decode stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_ir    <= NOP_INSTR;
            r_hold_pc    <= 32'd0;
        end else if (w_redirect) begin
            r_hold_valid <= 1'b0;
        end else if (w_capture) begin
            r_hold_valid <= 1'b1;
            r_hold_ir    <= bus.imem_rdata;
            r_hold_pc    <= r_req_pc;
        end else if (w_hold_out) begin
            r_hold_valid <= 1'b0;
        end
    end

    // IF/ID registers: flushed by redirect, frozen by stall, otherwise
    // loaded with the delivered word or a bubble (PC kept on a bubble).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_id_ir    <= NOP_INSTR;
            r_if_id_pc    <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else if (w_redirect) begin
            r_if_id_ir    <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (!w_stall) begin
            if (w_resp_live) begin
                r_if_id_ir    <= bus.imem_rdata;
                r_if_id_pc    <= r_req_pc;
                r_if_id_valid <= 1'b1;
            end else if (w_hold_out) begin
                r_if_id_ir    <= r_hold_ir;
                r_if_id_pc    <= r_hold_pc;
                r_if_id_valid <= 1'b1;
            end else begin
                r_if_id_ir    <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
            end
        end
    end

    assign bus.imem_req    = w_imem_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.if_id_ir    = r_if_id_ir;
    assign bus.if_id_pc    = r_if_id_pc;
    assign bus.if_id_valid = r_if_id_valid;
    assign bus.dbg_state   = w_dbg_state;

endmodule
